// File: rtl/and_gate.sv
// Bitwise AND with a combinational path, a valid-qualified registered path, and a
// saturating counter of accepted all-ones results.
module and_gate #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             all_ones,
  output logic [CNT_W-1:0] match_cnt
);

  logic [WIDTH-1:0] y_d;
  logic             valid_d;
  logic [CNT_W-1:0] cnt_d;
  logic             match;

  // Combinational result, valid during reset as well.
  assign y     = a & b;
  assign match = in_valid & (&y);

  always_comb begin
    y_d     = y_q;
    valid_d = 1'b0;
    cnt_d   = match_cnt;
    if (in_valid) begin
      y_d     = y;
      valid_d = 1'b1;
    end
    // Saturate rather than wrap.
    if (match && (match_cnt != {CNT_W{1'b1}})) begin
      cnt_d = match_cnt + CNT_W'(1);
    end
  end

  // Reset wins over a coincident sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      out_valid <= 1'b0;
      match_cnt <= '0;
    end else begin
      y_q       <= y_d;
      out_valid <= valid_d;
      match_cnt <= cnt_d;
    end
  end

  assign all_ones = out_valid & (&y_q);

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: a WIDTH=8 instance driven from a vector table and a
// WIDTH=1, CNT_W=2 instance driven by hand-written truth-table and saturation sequences.
module tb_and_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // WIDTH=8 instance
  logic       rst8, iv8;
  logic [7:0] a8, b8, y8, yq8;
  logic       ov8, all8;
  logic [15:0] cnt8;

  // WIDTH=1, CNT_W=2 instance
  logic       rst1, iv1;
  logic [0:0] a1, b1, y1, yq1;
  logic       ov1, all1;
  logic [1:0] cnt1;

  and_gate #(.WIDTH(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst(rst8), .a(a8), .b(b8), .in_valid(iv8),
    .y(y8), .y_q(yq8), .out_valid(ov8), .all_ones(all8), .match_cnt(cnt8)
  );

  and_gate #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .in_valid(iv1),
    .y(y1), .y_q(yq1), .out_valid(ov1), .all_ones(all1), .match_cnt(cnt1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_y;
    logic [7:0] exp_yq;
    logic       exp_ov;
    logic       exp_all;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 1'b1, 8'hF0, 8'h3C, 8'h30, 8'h30, 1'b1, 1'b0, 16'd0};
    vecs[2] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 16'd1};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 16'd1};
    vecs[4] = '{1'b0, 1'b0, 8'hAA, 8'h55, 8'h00, 8'hFF, 1'b0, 1'b0, 16'd1};
    vecs[5] = '{1'b0, 1'b0, 8'h12, 8'h34, 8'h10, 8'hFF, 1'b0, 1'b0, 16'd1};
    vecs[6] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 16'd2};
    vecs[7] = '{1'b0, 1'b1, 8'hFE, 8'hFF, 8'hFE, 8'hFE, 1'b1, 1'b0, 16'd2};
    vecs[8] = '{1'b1, 1'b1, 8'hC3, 8'h0F, 8'h03, 8'h00, 1'b0, 1'b0, 16'd0};
    vecs[9] = '{1'b0, 1'b1, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 1'b1, 1'b0, 16'd0};

    rst8 = 1'b1; iv8 = 1'b0; a8 = '0; b8 = '0;
    rst1 = 1'b1; iv1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst8_yq", yq8, 0);
    chk("rst8_ov", ov8, 0);
    chk("rst8_all", all8, 0);
    chk("rst8_cnt", cnt8, 0);
    chk("rst1_all", all1, 0);
    chk("rst1_cnt", cnt1, 0);

    // Truth table on y while reset is still held: purely combinational.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = 1'(i >> 1);
      b1 = 1'(i);
      #1 chk($sformatf("tt_y_%0d", i), y1, (i == 3) ? 1 : 0);
    end

    @(negedge clk);
    rst8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst8 = vecs[i].rst; iv8 = vecs[i].iv; a8 = vecs[i].a; b8 = vecs[i].b;
      #1 chk($sformatf("v%0d_y", i), y8, vecs[i].exp_y);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_yq", i), yq8, vecs[i].exp_yq);
      chk($sformatf("v%0d_ov", i), ov8, vecs[i].exp_ov);
      chk($sformatf("v%0d_all", i), all8, vecs[i].exp_all);
      chk($sformatf("v%0d_cnt", i), cnt8, vecs[i].exp_cnt);
    end
    @(negedge clk);
    iv8 = 1'b0; rst8 = 1'b0;

    // Saturation on the 2-bit counter: 1,2,3,3,3.
    @(negedge clk);
    rst1 = 1'b0; iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat_cnt_%0d", i), cnt1, (i < 3) ? i + 1 : 3);
      chk($sformatf("sat_yq_%0d", i), yq1, 1);
      chk($sformatf("sat_ov_%0d", i), ov1, 1);
      chk($sformatf("sat_all_%0d", i), all1, 1);
    end

    // Reset mid-stream with a coincident all-ones sample.
    @(negedge clk);
    rst1 = 1'b1;
    #1 chk("midrst_y_before", y1, 1);
    @(posedge clk);
    #1;
    chk("midrst_yq", yq1, 0);
    chk("midrst_ov", ov1, 0);
    chk("midrst_all", all1, 0);
    chk("midrst_cnt", cnt1, 0);
    chk("midrst_y", y1, 1);

    // Hold after a load with in_valid low: y_q keeps 1, valid and all_ones drop.
    @(negedge clk);
    rst1 = 1'b0;
    @(posedge clk);
    #1 chk("hold_load_cnt", cnt1, 1);
    @(negedge clk);
    iv1 = 1'b0; a1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_yq_%0d", i), yq1, 1);
      chk($sformatf("hold_ov_%0d", i), ov1, 0);
      chk($sformatf("hold_all_%0d", i), all1, 0);
      chk($sformatf("hold_cnt_%0d", i), cnt1, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
